// File: rtl/fwd_pkg.sv
// Shared select encodings and pipeline tracking-entry types for the EX-stage forwarding/hazard control.
package fwd_pkg;

  localparam int ADDR_W      = 5;
  localparam int STALL_CNT_W = 32;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_ALT   = 2'b11;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // EX entry keeps the load flag so the load-use check can see it.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              we;
    logic              load;
    logic              valid;
  } ex_ent_t;

  // Producer view seen by the source matchers; also the MEM entry format.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              we;
    logic              valid;
  } prod_ent_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction info in, operand selects and hazard status out.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  id_use_pc;
  logic                  id_use_imm;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;
  logic [1:0]            sel_a;
  logic [1:0]            sel_b;
  logic                  stall;
  logic                  ex_valid;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_use_pc,
           id_use_imm, id_rd, id_reg_write, id_mem_read, flush,
    input  sel_a, sel_b, stall, ex_valid, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_use_pc,
           id_use_imm, id_rd, id_reg_write, id_mem_read, flush,
    output sel_a, sel_b, stall, ex_valid, stall_count
  );
endinterface

// File: rtl/fwd_src_match.sv
// Combinational forwarding select for one source operand; the EX-stage producer outranks MEM.
module fwd_src_match
  import fwd_pkg::*;
(
  input  logic [ADDR_W-1:0] i_rs,
  input  logic              i_uses,
  input  prod_ent_t         i_ex,
  input  prod_ent_t         i_mem,
  output logic [1:0]        o_sel
);

  always_comb begin
    o_sel = SEL_RF;
    if (i_uses && (i_rs != REG_ZERO)) begin
      if (i_ex.valid && i_ex.we && (i_ex.rd == i_rs)) begin
        o_sel = SEL_EXMEM;
      end else if (i_mem.valid && i_mem.we && (i_mem.rd == i_rs)) begin
        o_sel = SEL_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Tracks EX/MEM destinations, registers operand-mux selects for the instruction entering EX,
// and raises a one-cycle load-use stall (flush overrides stall and inserts a bubble).
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = ADDR_W,
  parameter int CNT_W      = STALL_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_ctrl_if.slave   bus
);

  ex_ent_t              r_ex;
  prod_ent_t            r_mem;
  logic [1:0]           r_sel_a;
  logic [1:0]           r_sel_b;
  logic [CNT_W-1:0]     r_stall_count;

  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  prod_ent_t             w_ex_prod;
  logic [1:0]            w_fwd_a;
  logic [1:0]            w_fwd_b;
  logic                  w_ld_hit;
  logic                  w_stall;
  logic                  w_issue;
  ex_ent_t               w_ex_nxt;
  logic [1:0]            w_sel_a_nxt;
  logic [1:0]            w_sel_b_nxt;

  assign w_rs1     = bus.id_rs1;
  assign w_rs2     = bus.id_rs2;
  assign w_ex_prod = '{rd: r_ex.rd, we: r_ex.we, valid: r_ex.valid};

  fwd_src_match u_match_rs1 (
    .i_rs   (w_rs1),
    .i_uses (bus.id_uses_rs1),
    .i_ex   (w_ex_prod),
    .i_mem  (r_mem),
    .o_sel  (w_fwd_a)
  );

  fwd_src_match u_match_rs2 (
    .i_rs   (w_rs2),
    .i_uses (bus.id_uses_rs2),
    .i_ex   (w_ex_prod),
    .i_mem  (r_mem),
    .o_sel  (w_fwd_b)
  );

  // A load in EX cannot forward yet; its data only exists once it reaches MEM/WB.
  assign w_ld_hit = r_ex.valid && r_ex.load && r_ex.we && (r_ex.rd != REG_ZERO) &&
                    ((bus.id_uses_rs1 && (w_rs1 == r_ex.rd)) ||
                     (bus.id_uses_rs2 && (w_rs2 == r_ex.rd)));
  assign w_stall  = bus.id_valid && !bus.flush && w_ld_hit;
  assign w_issue  = bus.id_valid && !bus.flush && !w_stall;

  always_comb begin
    w_ex_nxt    = '0;
    w_sel_a_nxt = SEL_RF;
    w_sel_b_nxt = SEL_RF;
    if (w_issue) begin
      w_ex_nxt.rd    = bus.id_rd;
      w_ex_nxt.we    = bus.id_reg_write;
      w_ex_nxt.load  = bus.id_mem_read;
      w_ex_nxt.valid = 1'b1;
      w_sel_a_nxt    = bus.id_use_pc  ? SEL_ALT : w_fwd_a;
      w_sel_b_nxt    = bus.id_use_imm ? SEL_ALT : w_fwd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_sel_a       <= SEL_RF;
      r_sel_b       <= SEL_RF;
      r_stall_count <= '0;
    end else begin
      r_ex    <= w_ex_nxt;
      r_mem   <= w_ex_prod;
      r_sel_a <= w_sel_a_nxt;
      r_sel_b <= w_sel_b_nxt;
      if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign bus.sel_a       = r_sel_a;
  assign bus.sel_b       = r_sel_b;
  assign bus.stall       = w_stall;
  assign bus.ex_valid    = r_ex.valid;
  assign bus.stall_count = r_stall_count;

endmodule
